// File: rtl/master_out_port.sv
// master_out_port: serializes a parallel request onto rx_address/rx_data of slave_in_port.
// Optional multi-beat write bursts are compiled in when BURST_EN is defined.
`timescale 1ns/1ps
module master_out_port #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int BURST_W = 12
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_data,
`ifdef BURST_EN
    input  logic [BURST_W-1:0] req_burst,
    input  logic               beat_valid,
    input  logic [DATA_W-1:0]  beat_data,
    output logic               beat_ready,
`endif
    input  logic               s_ready,
    output logic               m_valid,
    output logic               write_enable,
    output logic               read_enable,
    output logic               tx_address,
    output logic               tx_data,
    output logic               tx_done
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT, ADDR, DATA, STALL, DONE
    } state_t;

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [ADDR_W-1:0]  addr_q, nxt_addr;
    logic [DATA_W-1:0]  data_q, nxt_data;
    logic               wr_q, nxt_wr;
    logic [BURST_W-1:0] beats_q, nxt_beats;
    logic               ld, last;

    logic               bv;
    logic [DATA_W-1:0]  bd;
    logic [BURST_W-1:0] burst_in;

`ifdef BURST_EN
    assign bv       = beat_valid;
    assign bd       = beat_data;
    assign burst_in = req_burst;
`else
    assign bv       = 1'b0;
    assign bd       = '0;
    assign burst_in = '0;
`endif

    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] data_sh;
    logic req_ready_d, m_valid_d, we_d, re_d;
    logic ta_d, td_d, done_d, first;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            beats_q <= '0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            addr_q  <= nxt_addr;
            data_q  <= nxt_data;
            wr_q    <= nxt_wr;
            beats_q <= nxt_beats;
        end
    end

    // Next state: accept, wait for slave, shift address then any burst bytes
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_addr  = addr_q;
        nxt_data  = data_q;
        nxt_wr    = wr_q;
        nxt_beats = beats_q;
        ld        = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    nxt_addr  = req_addr;
                    nxt_data  = req_data;
                    nxt_wr    = req_write;
                    nxt_beats = burst_in;
                    nxt_cnt   = '0;
                    nxt_state = WAIT;
                end
            end
            WAIT: begin
                if (s_ready) begin
                    nxt_cnt   = '0;
                    nxt_state = ADDR;
                end
            end
            ADDR: begin
                if (cnt == ADDR_LAST) last = 1'b1;
                else nxt_cnt = cnt + 1'b1;
            end
            DATA: begin
                if (cnt == DATA_LAST) last = 1'b1;
                else nxt_cnt = cnt + 1'b1;
            end
            STALL: begin
                if (bv) begin
                    ld        = 1'b1;
                    nxt_state = DATA;
                end
            end
            DONE: nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
        // end of a bit run: fetch another byte, stall for it, or finish
        if (last) begin
            nxt_cnt = '0;
            if (wr_q && (beats_q != '0)) begin
                if (bv) begin
                    ld        = 1'b1;
                    nxt_state = DATA;
                end else begin
                    nxt_state = STALL;
                end
            end else begin
                nxt_state = DONE;
            end
        end
        if (ld) begin
            nxt_data  = bd;
            nxt_beats = beats_q - 1'b1;
        end
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        addr_sh     = nxt_addr << nxt_cnt;
        data_sh     = nxt_data << nxt_cnt;
        req_ready_d = (nxt_state == IDLE);
        m_valid_d   = (nxt_state == ADDR) || (nxt_state == DATA);
        first       = (nxt_state == ADDR) && (nxt_cnt == '0);
        we_d        = first && nxt_wr;
        re_d        = first && !nxt_wr;
        ta_d        = (nxt_state == ADDR) && addr_sh[ADDR_W-1];
        td_d        = (((nxt_state == ADDR) && nxt_wr && (nxt_cnt <= DATA_LAST))
                      || (nxt_state == DATA)) && data_sh[DATA_W-1];
        done_d      = (nxt_state == DONE);
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_ready    <= 1'b1;
            m_valid      <= 1'b0;
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
            tx_address   <= 1'b0;
            tx_data      <= 1'b0;
            tx_done      <= 1'b0;
`ifdef BURST_EN
            beat_ready   <= 1'b0;
`endif
        end else begin
            req_ready    <= req_ready_d;
            m_valid      <= m_valid_d;
            write_enable <= we_d;
            read_enable  <= re_d;
            tx_address   <= ta_d;
            tx_data      <= td_d;
            tx_done      <= done_d;
`ifdef BURST_EN
            beat_ready   <= ld;
`endif
        end
    end

endmodule

// File: tb/tb_master_out_port.sv
// Testbench for master_out_port: per-cycle expected trace built from the
// transfer rules, random stimulus on all don't-care inputs, literal anchors.
`timescale 1ns/1ps
module tb_master_out_port;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int BW = 12;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_write, s_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data, beat_data;
    logic [BW-1:0] req_burst;
    logic          beat_valid, br_w;
    logic          m_valid, write_enable, read_enable;
    logic          tx_address, tx_data, tx_done;

    master_out_port #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
`ifdef BURST_EN
        .req_burst(req_burst), .beat_valid(beat_valid),
        .beat_data(beat_data), .beat_ready(br_w),
`endif
        .s_ready(s_ready), .m_valid(m_valid),
        .write_enable(write_enable), .read_enable(read_enable),
        .tx_address(tx_address), .tx_data(tx_data), .tx_done(tx_done)
    );
`ifndef BURST_EN
    assign br_w = 1'b0;
`endif

    // {req_ready, m_valid, we, re, tx_address, tx_data, tx_done, beat_ready}
    logic [7:0] outv;
    assign outv = {req_ready, m_valid, write_enable, read_enable,
                   tx_address, tx_data, tx_done, br_w};

    typedef struct packed {
        logic          rv;
        logic          wr;
        logic [AW-1:0] ad;
        logic [DW-1:0] dt;
        logic [BW-1:0] bu;
        logic          sr;
        logic          bv;
        logic [DW-1:0] bd;
        logic [7:0]    ex;
    } cyc_t;

    cyc_t       sched[$];
    logic [7:0] bq[$];
    int         sq[$];

    int errors = 0;
    int checks = 0;
    int cur = 0;
    bit active = 0;

    logic [31:0] cap_a, cap_d;
    int cap_n, lat, cyc, nbr;

    function automatic cyc_t rnd();
        cyc_t c;
        c.rv = 1'($urandom);
        c.wr = 1'($urandom);
        c.ad = AW'($urandom);
        c.dt = DW'($urandom);
        c.bu = BW'($urandom);
        c.sr = 1'($urandom);
        c.bv = 1'($urandom);
        c.bd = DW'($urandom);
        c.ex = '0;
        return c;
    endfunction

    // beat k is sampled at the end of a bit run: present it now only if it has no stall
    function automatic cyc_t lastbit(cyc_t ci, int k, int nb);
        cyc_t c = ci;
        if (k < nb) begin
            if (sq[k] == 0) begin
                c.bv = 1'b1;
                c.bd = bq[k];
            end else begin
                c.bv = 1'b0;
            end
        end
        return c;
    endfunction

    task automatic add_txn(input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int burst,
                           input int gap, input int sd);
        int nb;
        cyc_t c;
        nb = 0;
`ifdef BURST_EN
        if (wr) nb = burst;
`endif
        for (int i = 0; i < gap; i++) begin
            c = rnd(); c.rv = 1'b0; c.ex = 8'h80; sched.push_back(c);
        end
        c = rnd();
        c.rv = 1'b1; c.wr = wr; c.ad = a; c.dt = d; c.bu = BW'(burst);
        c.ex = 8'h80;
        sched.push_back(c);
        for (int i = 0; i <= sd; i++) begin
            c = rnd(); c.sr = (i == sd); c.ex = 8'h00; sched.push_back(c);
        end
        for (int i = 0; i < AW; i++) begin
            c = rnd();
            c.ex = {1'b0, 1'b1, wr && (i == 0), !wr && (i == 0), a[AW-1-i],
                    (wr && i < DW) ? d[DW-1-i] : 1'b0, 2'b00};
            if (i == AW - 1) c = lastbit(c, 0, nb);
            sched.push_back(c);
        end
        for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < sq[k]; j++) begin
                c = rnd(); c.bv = (j == sq[k] - 1); c.bd = bq[k]; c.ex = 8'h00;
                sched.push_back(c);
            end
            for (int i = 0; i < DW; i++) begin
                c = rnd();
                c.ex = {4'b0100, 1'b0, bq[k][DW-1-i], 1'b0, (i == 0)};
                if (i == DW - 1) c = lastbit(c, k + 1, nb);
                sched.push_back(c);
            end
        end
        c = rnd(); c.ex = 8'h02; sched.push_back(c);
    endtask

    task automatic drive(input cyc_t c);
        req_valid  = c.rv;
        req_write  = c.wr;
        req_addr   = c.ad;
        req_data   = c.dt;
        req_burst  = c.bu;
        s_ready    = c.sr;
        beat_valid = c.bv;
        beat_data  = c.bd;
    endtask

    task automatic drive_idle();
        cyc_t c;
        c = '0;
        drive(c);
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(sched[i]);
            cur = i;
            active = 1;
        end
        @(posedge clk); #1;
        active = 0;
        drive_idle();
        sched.delete();
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Compare DUT outputs with the expected trace every cycle; capture serial streams
    always @(negedge clk) begin
        if (active) begin
            checks++;
            if (outv !== sched[cur].ex) begin
                errors++;
                $display("FAIL trace step %0d: outputs got %b expected %b",
                         cur, outv, sched[cur].ex);
            end
            if (sched[cur].rv && req_ready) begin
                cap_a = 0; cap_d = 0; cap_n = 0; lat = 0; cyc = 0; nbr = 0;
            end else begin
                cyc++;
                if (m_valid) begin
                    if (cap_n == 0) lat = cyc;
                    cap_a = {cap_a[30:0], tx_address};
                    cap_d = {cap_d[30:0], tx_data};
                    cap_n++;
                end
                if (br_w) nbr++;
            end
        end
    end

    initial begin
        drive_idle();
        rstn = 1'b0;
        #12;
        chk("reset_outputs", {24'h0, outv}, 32'h80);
        @(posedge clk); #1;
        rstn = 1'b1;

        add_txn(1'b1, 12'hA5C, 8'h3B, 0, 1, 0);
        play(sched.size());
        chk("t1_addr_stream", cap_a & 32'hFFF, 32'hA5C);
        chk("t1_data_stream", cap_d & 32'hFFF, 32'h3B0);
        chk("t1_bits", cap_n, 12);
        chk("t1_latency", lat, 2);

        add_txn(1'b0, 12'h001, 8'hFF, 3, 0, 0);
        play(sched.size());
        chk("t2_addr_stream", cap_a & 32'hFFF, 32'h001);
        chk("t2_data_stream", cap_d & 32'hFFF, 32'h000);
        chk("t2_bits", cap_n, 12);

        add_txn(1'b1, 12'h3C7, 8'h81, 0, 0, 5);
        play(sched.size());
        chk("t3_latency", lat, 7);
        chk("t3_bits", cap_n, 12);

        bq = '{8'h11, 8'h22};
        sq = '{0, 3};
        add_txn(1'b1, 12'h100, 8'h5E, 2, 0, 0);
        play(sched.size());
`ifdef BURST_EN
        chk("t4_bits", cap_n, 28);
        chk("t4_beat_ready", nbr, 2);
        chk("t4_last_byte", cap_d & 32'hFF, 32'h22);
`else
        chk("t4_bits", cap_n, 12);
        chk("t4_beat_ready", nbr, 0);
        chk("t4_last_byte", cap_d & 32'hFF, 32'hE0);
`endif

        for (int t = 0; t < 40; t++) begin
            int nb;
            nb = $urandom_range(0, 3);
            bq.delete();
            sq.delete();
            for (int k = 0; k < nb; k++) begin
                bq.push_back(8'($urandom));
                sq.push_back($urandom_range(0, 2));
            end
            add_txn(1'($urandom), AW'($urandom), DW'($urandom), nb,
                    $urandom_range(0, 2), $urandom_range(0, 3));
            play(sched.size());
        end

        bq.delete();
        sq.delete();
        for (int k = 0; k < 4095; k++) begin
            bq.push_back(8'(k) ^ 8'hA5);
            sq.push_back((k % 1000 == 7) ? 1 : 0);
        end
        add_txn(1'b1, 12'hFFF, 8'h80, 4095, 0, 0);
        play(sched.size());
`ifdef BURST_EN
        chk("allones_bits", cap_n, 12 + 4095 * 8);
        chk("allones_beat_ready", nbr, 4095);
`else
        chk("allones_bits", cap_n, 12);
        chk("allones_beat_ready", nbr, 0);
`endif

        add_txn(1'b1, 12'hFFF, 8'hFF, 0, 0, 0);
        play(7);
        #1 rstn = 1'b0;
        #1 chk("async_reset", {24'h0, outv}, 32'h80);
        @(posedge clk); #1;
        chk("reset_held", {24'h0, outv}, 32'h80);
        rstn = 1'b1;

        add_txn(1'b1, 12'h5A3, 8'hC6, 0, 0, 0);
        play(sched.size());
        chk("post_reset_addr", cap_a & 32'hFFF, 32'h5A3);
        chk("post_reset_data", cap_d & 32'hFFF, 32'hC60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
